// File: rtl/pz_sequencer.sv
// Instruction sequencer for the puzzle-solver ALU: fetch, decode, execute, write back.
// Optional retired-instruction counter enabled by defining SEQ_RETIRE_CNT_EN.
module pz_sequencer #(
  parameter int         NREG     = 16,
  parameter logic [7:0] START_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        rom_req,
  output logic [7:0]  rom_addr,
  input  logic        rom_ack,
  input  logic [23:0] rom_data,
  output logic [7:0]  alu_op,
  output logic [7:0]  alu_ina,
  output logic [7:0]  alu_inb,
  input  logic [7:0]  alu_out,
  input  logic        alu_zf,
  output logic        busy,
  output logic        done,
  output logic        zf,
  output logic [7:0]  pc,
  input  logic [3:0]  dbg_addr,
  output logic [7:0]  dbg_data
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0] retired_cnt
`endif
);

  // ALU command encodings mirror commands.h; sequencer-local opcodes live at F0..F3.
  localparam logic [7:0] OP_SET    = 8'h00;
  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_SUB    = 8'h02;
  localparam logic [7:0] OP_WRITE  = 8'h03;
  localparam logic [7:0] OP_CHECK  = 8'h04;
  localparam logic [7:0] OP_LESS   = 8'h05;
  localparam logic [7:0] OP_ADDREG = 8'h06;
  localparam logic [7:0] OP_CHECKR = 8'h07;
  localparam logic [7:0] OP_COPY   = 8'h08;
  localparam logic [7:0] OP_AUP    = 8'h09;
  localparam logic [7:0] OP_ADW    = 8'h0A;
  localparam logic [7:0] OP_MOD    = 8'h0B;
  localparam logic [7:0] OP_DIV    = 8'h0C;
  localparam logic [7:0] OP_INV    = 8'h0D;
  localparam logic [7:0] OP_JMP    = 8'hF0;
  localparam logic [7:0] OP_JZ     = 8'hF1;
  localparam logic [7:0] OP_JNZ    = 8'hF2;
  localparam logic [7:0] OP_HALT   = 8'hF3;
  localparam logic [7:0] OP_IDLE   = 8'hFF;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALTED} state_t;

  state_t      r_state;
  logic [23:0] r_instr;
  logic [7:0]  r_pc;
  logic        r_zf;
  logic        r_rom_req;
  logic [7:0]  r_rom_addr;
  logic [7:0]  r_alu_op;
  logic [7:0]  r_alu_ina;
  logic [7:0]  r_alu_inb;
  logic        r_busy;
  logic        r_done;

  logic [7:0]  w_op;
  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [3:0]  w_dst;
  logic        w_is_imm;
  logic        w_is_reg;
  logic        w_is_flag;
  logic        w_is_write;
  logic        w_is_jump;
  logic        w_is_halt;
  logic        w_wr_en;
  logic [7:0]  w_pc_inc;
  logic [7:0]  w_jump_pc;
  logic [7:0]  w_regs [16];

  assign w_op  = r_instr[23:16];
  assign w_a   = r_instr[15:8];
  assign w_b   = r_instr[7:0];
  assign w_dst = w_b[3:0];

  always_comb begin
    w_is_imm  = 1'b0;
    w_is_reg  = 1'b0;
    w_is_flag = 1'b0;
    case (w_op)
      OP_SET, OP_ADD, OP_SUB, OP_WRITE: w_is_imm = 1'b1;
      OP_CHECK, OP_LESS: begin
        w_is_imm  = 1'b1;
        w_is_flag = 1'b1;
      end
      OP_CHECKR: begin
        w_is_reg  = 1'b1;
        w_is_flag = 1'b1;
      end
      OP_ADDREG, OP_COPY, OP_AUP, OP_ADW, OP_MOD, OP_DIV, OP_INV: w_is_reg = 1'b1;
      default: ;
    endcase
  end

  // Compares only update the flag; unknown opcodes neither write nor touch zf.
  assign w_is_write = (w_is_imm | w_is_reg) & ~w_is_flag;
  assign w_is_jump  = (w_op == OP_JMP) | (w_op == OP_JZ) | (w_op == OP_JNZ);
  assign w_is_halt  = (w_op == OP_HALT);
  assign w_wr_en    = (r_state == S_WB) & w_is_write;
  assign w_pc_inc   = r_pc + 8'd1;
  assign w_jump_pc  = ((w_op == OP_JMP) || (w_op == OP_JZ && r_zf) || (w_op == OP_JNZ && !r_zf))
                      ? w_a : w_pc_inc;

  // Index field is always 4 bits wide; slots beyond NREG read as zero and ignore writes.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg
      if (gi < NREG) begin : g_on
        logic [7:0] r_q;
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_q <= 8'h00;
          end else if (w_wr_en && (w_dst == 4'(gi))) begin
            r_q <= alu_out;
          end
        end
        assign w_regs[gi] = r_q;
      end else begin : g_off
        assign w_regs[gi] = 8'h00;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_instr    <= 24'h000000;
      r_pc       <= START_PC;
      r_zf       <= 1'b0;
      r_rom_req  <= 1'b0;
      r_rom_addr <= 8'h00;
      r_alu_op   <= OP_IDLE;
      r_alu_ina  <= 8'h00;
      r_alu_inb  <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc       <= START_PC;
            r_rom_addr <= START_PC;
            r_rom_req  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rom_ack) begin
            r_instr   <= rom_data;
            r_rom_req <= 1'b0;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_jump) begin
            r_pc       <= w_jump_pc;
            r_rom_addr <= w_jump_pc;
            r_rom_req  <= 1'b1;
            r_state    <= S_FETCH;
          end else if (w_is_halt) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_HALTED;
          end else begin
            r_alu_op  <= w_op;
            r_alu_ina <= w_is_reg ? w_regs[w_a[3:0]] : w_a;
            r_alu_inb <= w_regs[w_dst];
            r_state   <= S_WB;
          end
        end
        S_WB: begin
          if (w_is_flag) begin
            r_zf <= alu_zf;
          end
          r_pc       <= w_pc_inc;
          r_rom_addr <= w_pc_inc;
          r_rom_req  <= 1'b1;
          r_alu_op   <= OP_IDLE;
          r_alu_ina  <= 8'h00;
          r_alu_inb  <= 8'h00;
          r_state    <= S_FETCH;
        end
        S_HALTED: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] r_retired;
  logic        w_retire;

  assign w_retire = ((r_state == S_EXEC) && (w_is_jump || w_is_halt)) || (r_state == S_WB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired <= 16'h0000;
    end else if ((r_state == S_IDLE) && start) begin
      r_retired <= 16'h0000;
    end else if (w_retire && (r_retired != 16'hFFFF)) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign retired_cnt = r_retired;
`endif

  assign rom_req  = r_rom_req;
  assign rom_addr = r_rom_addr;
  assign alu_op   = r_alu_op;
  assign alu_ina  = r_alu_ina;
  assign alu_inb  = r_alu_inb;
  assign busy     = r_busy;
  assign done     = r_done;
  assign zf       = r_zf;
  assign pc       = r_pc;
  assign dbg_data = w_regs[dbg_addr];

endmodule

// File: tb/tb_pz_sequencer.sv
// Bench for pz_sequencer: ROM/ALU models, instruction-level reference model checked every cycle.
// Define SEQ_RETIRE_CNT_EN to also exercise the retire counter.
module tb_pz_sequencer;

  localparam logic [7:0] OP_SET    = 8'h00;
  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_SUB    = 8'h02;
  localparam logic [7:0] OP_WRITE  = 8'h03;
  localparam logic [7:0] OP_CHECK  = 8'h04;
  localparam logic [7:0] OP_LESS   = 8'h05;
  localparam logic [7:0] OP_ADDREG = 8'h06;
  localparam logic [7:0] OP_CHECKR = 8'h07;
  localparam logic [7:0] OP_COPY   = 8'h08;
  localparam logic [7:0] OP_AUP    = 8'h09;
  localparam logic [7:0] OP_ADW    = 8'h0A;
  localparam logic [7:0] OP_MOD    = 8'h0B;
  localparam logic [7:0] OP_DIV    = 8'h0C;
  localparam logic [7:0] OP_INV    = 8'h0D;
  localparam logic [7:0] OP_JMP    = 8'hF0;
  localparam logic [7:0] OP_JZ     = 8'hF1;
  localparam logic [7:0] OP_JNZ    = 8'hF2;
  localparam logic [7:0] OP_HALT   = 8'hF3;
  localparam logic [7:0] START     = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n, start, rom_req, rom_ack, alu_zf, busy, done, zf, force_ack;
  logic [7:0]  rom_addr, alu_op, alu_ina, alu_inb, alu_out, pc, dbg_data;
  logic [3:0]  dbg_addr;
  logic [23:0] rom_data;
  logic [23:0] rom [256];
`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] retired_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int rom_delay = 0;
  int wait_cnt = 0;
  bit mon_en = 1'b0;
  logic [7:0] fetch_log [$];
  logic [7:0] exp_t3 [4] = '{8'h00, 8'h01, 8'h02, 8'h10};

  always #5 clk = ~clk;

  pz_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_out(alu_out), .alu_zf(alu_zf),
    .busy(busy), .done(done), .zf(zf), .pc(pc),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef SEQ_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  // ROM answers after rom_delay waiting cycles; force_ack injects stray acks.
  assign rom_data = rom[rom_addr];
  assign rom_ack  = (rom_req && (wait_cnt >= rom_delay)) || force_ack;
  always @(posedge clk) begin
    if (!rom_req || rom_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  function automatic logic [8:0] alu_calc(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] o;
    logic       z;
    o = 8'hA5;
    z = 1'b0;
    case (op)
      OP_SET, OP_WRITE, OP_COPY: o = a;
      OP_ADD, OP_ADDREG, OP_ADW: o = a + b;
      OP_SUB:                    o = b - a;
      OP_AUP:                    o = a + 8'd1;
      OP_MOD:                    o = (a == 8'h00) ? 8'h00 : (b % a);
      OP_DIV:                    o = (a == 8'h00) ? 8'h00 : (b / a);
      OP_INV:                    o = ~a;
      OP_CHECK, OP_CHECKR: begin o = 8'h00; z = (a == b); end
      OP_LESS:             begin o = 8'h00; z = (b < a); end
      default: ;
    endcase
    return {z, o};
  endfunction

  assign {alu_zf, alu_out} = alu_calc(alu_op, alu_ina, alu_inb);

  function automatic bit is_imm(input logic [7:0] op);
    return op inside {OP_SET, OP_ADD, OP_SUB, OP_WRITE, OP_CHECK, OP_LESS};
  endfunction
  function automatic bit is_regop(input logic [7:0] op);
    return op inside {OP_ADDREG, OP_CHECKR, OP_COPY, OP_AUP, OP_ADW, OP_MOD, OP_DIV, OP_INV};
  endfunction
  function automatic bit is_flag(input logic [7:0] op);
    return op inside {OP_CHECK, OP_CHECKR, OP_LESS};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: architectural state plus the documented latencies (ack, +1 exec, +2 result).
  logic [7:0]  m_regs [16];
  logic [7:0]  m_pc = START;
  logic        m_zf = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_fetch = 1'b0;
  int          m_since = -1;
  logic [23:0] m_cur = 24'h000000;

  always @(negedge clk) begin : model
    logic [7:0] op, a, b, ea, eb;
    logic [8:0] r;
    bit jmp, hlt, show_alu, taken;
    op = m_cur[23:16];
    a  = m_cur[15:8];
    b  = m_cur[7:0];
    jmp = op inside {OP_JMP, OP_JZ, OP_JNZ};
    hlt = (op == OP_HALT);
    show_alu = (m_since == 2) && !jmp && !hlt;
    ea = is_regop(op) ? m_regs[a[3:0]] : a;
    eb = m_regs[b[3:0]];
    if (mon_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, (m_since == 2) && hlt);
      chk("rom_req", rom_req, m_fetch);
      if (m_fetch) chk("rom_addr", rom_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("zf", zf, m_zf);
      chk("alu_op", alu_op, show_alu ? op : 8'hFF);
      if (!show_alu || is_imm(op) || is_regop(op)) chk("alu_ina", alu_ina, show_alu ? ea : 8'h00);
      chk("alu_inb", alu_inb, show_alu ? eb : 8'h00);
      chk("dbg_data", dbg_data, m_regs[dbg_addr]);
    end
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_pc = START; m_zf = 1'b0; m_busy = 1'b0; m_fetch = 1'b0; m_since = -1;
    end else if (m_since == 1) begin
      if (jmp) begin
        taken = (op == OP_JMP) || (op == OP_JZ && m_zf) || (op == OP_JNZ && !m_zf);
        m_pc = taken ? a : m_pc + 8'd1;
        m_fetch = 1'b1;
        m_since = -1;
      end else begin
        if (hlt) m_busy = 1'b0;
        m_since = 2;
      end
    end else if (m_since == 2) begin
      if (!hlt) begin
        r = alu_calc(op, ea, eb);
        if (is_flag(op)) m_zf = r[8];
        else if (is_imm(op) || is_regop(op)) m_regs[b[3:0]] = r[7:0];
        m_pc = m_pc + 8'd1;
        m_fetch = 1'b1;
      end
      m_since = -1;
    end else if (m_fetch && rom_ack) begin
      fetch_log.push_back(m_pc);
      m_cur = rom[m_pc];
      m_fetch = 1'b0;
      m_since = 1;
    end else if (!m_busy && start) begin
      m_busy = 1'b1;
      m_fetch = 1'b1;
      m_pc = START;
    end
  end

  task automatic run_prog(input string name, input int delay);
    bit got;
    got = 1'b0;
    rom_delay = delay;
    fetch_log.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
    @(negedge clk); chk({name, "_retire_clear"}, retired_cnt, 16'h0000);
    @(posedge clk); #1;
`endif
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1 dbg_addr = dbg_addr + 4'd1;
    end
    chk({name, "_halt_reached"}, got, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reg(input string name, input logic [3:0] idx, input logic [7:0] exp);
    dbg_addr = idx;
    @(negedge clk); chk(name, dbg_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; force_ack = 1'b0; dbg_addr = 4'h0;
    for (int i = 0; i < 256; i++) rom[i] = {OP_HALT, 16'h0000};
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    chk("reset_alu_op", alu_op, 8'hFF);
    chk("reset_rom_addr", rom_addr, 8'h00);
    chk("reset_rom_req", rom_req, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_pc", pc, START);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic write then halt
    rom[0] = {OP_SET, 8'h07, 8'h03};
    rom[1] = {OP_HALT, 16'h0000};
    run_prog("t1", 0);
    @(negedge clk);
    chk("t1_done_one_cycle", done, 1'b0);
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_zf", zf, 1'b0);
    @(posedge clk); #1;
    chk_reg("t1_r3", 4'd3, 8'h07);

    // Register-register add
    rom[0] = {OP_SET, 8'h05, 8'h01};
    rom[1] = {OP_SET, 8'h09, 8'h02};
    rom[2] = {OP_ADDREG, 8'h01, 8'h02};
    rom[3] = {OP_HALT, 16'h0000};
    run_prog("t2", 0);
    chk_reg("t2_r2", 4'd2, 8'h0E);
    chk_reg("t2_r1", 4'd1, 8'h05);

    // Compare then branch taken
    rom[0] = {OP_SET, 8'h04, 8'h00};
    rom[1] = {OP_CHECK, 8'h04, 8'h00};
    rom[2] = {OP_JZ, 8'h10, 8'h00};
    rom[3] = {OP_SET, 8'hFF, 8'h00};
    rom[16] = {OP_HALT, 16'h0000};
    run_prog("t3", 0);
    chk("t3_zf", zf, 1'b1);
    chk("t3_pc", pc, 8'h10);
    chk("t3_nfetch", fetch_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < fetch_log.size()) chk("t3_fetch_pc", fetch_log[i], exp_t3[i]);
    chk_reg("t3_r0", 4'd0, 8'h04);
`ifdef SEQ_RETIRE_CNT_EN
    chk("t3_retired", retired_cnt, 16'd4);
`endif

    // Branch not taken with stalled ROM; unknown opcode must not write r0
    rom[0] = {OP_CHECK, 8'h01, 8'h00};
    rom[1] = {OP_JZ, 8'h10, 8'h00};
    rom[2] = {8'hE0, 8'h55, 8'h00};
    rom[3] = {OP_HALT, 16'h0000};
    run_prog("t4", 5);
    chk("t4_pc", pc, 8'h03);
    chk("t4_zf", zf, 1'b0);
    chk_reg("t4_r0", 4'd0, 8'h04);

    // Reset in the middle of a stalled fetch
    rom_delay = 1000;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); chk("t5_req_before_rst", rom_req, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_req_after_rst", rom_req, 1'b0);
    chk("t5_busy_after_rst", busy, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) chk_reg("t5_reg_cleared", 4'(i), 8'h00);
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    chk("t5_late_ack_busy", busy, 1'b0);
    chk("t5_late_ack_req", rom_req, 1'b0);
    @(posedge clk); #1;
    rom[0] = {OP_SET, 8'h07, 8'h03};
    rom[1] = {OP_HALT, 16'h0000};
    run_prog("t5", 0);
    chk("t5_nfetch", fetch_log.size(), 2);
    if (fetch_log.size() > 0) chk("t5_restart_pc", fetch_log[0], 8'h00);
    chk_reg("t5_r3", 4'd3, 8'h07);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pz_sequencer.md
Name: pz_sequencer

Overview:
- Instruction sequencer that drives the puzzle-solver ALU: fetches 24-bit instructions from program ROM, decodes them into ALU op/operand pairs, and writes ALU results back to a 16x8 register file.
- Owns the zero flag history, PC and control flow. The ALU stays purely combinational and is driven solely by this block.

Parameters:
- NREG, 16, number of 8-bit general registers (index field width fixed at 4 bits).
- START_PC, 8'h00, PC loaded on start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins execution at START_PC when idle
- rom_req  out  1  fetch request; held until rom_ack
- rom_addr  out  8  fetch address (= pc)
- rom_ack  in  1  ROM data valid this cycle
- rom_data  in  24  instruction {op[23:16], a[15:8], b[7:0]}
- alu_op  out  8  ALU opcode
- alu_ina  out  8  ALU operand A
- alu_inb  out  8  ALU operand B
- alu_out  in  8  ALU result
- alu_zf  in  1  ALU compare result
- busy  out  1  high from start until halt
- done  out  1  one-cycle pulse on HALT
- zf  out  1  architectural zero flag
- pc  out  8  current PC
- dbg_addr  in  4  register-file debug read index
- dbg_data  out  8  combinational read of reg[dbg_addr]

Behaviour:
- Clock `clk`, reset `rst_n`: one clock, reset synchronous and active-low.
- Reset: state=IDLE, pc=START_PC, all regs=0, zf=0, rom_req=0, rom_addr=0, alu_op=8'hFF, alu_ina=alu_inb=0, busy=0, done=0. Reset mid-fetch drops rom_req on that edge; a late rom_ack is ignored.
- Opcodes:
  - ALU commands use the team's commands.h encodings, all < 8'hF0.
  - Sequencer-local opcodes: JMP=F0, JZ=F1, JNZ=F2, HALT=F3.
  - 8'hFF is the idle op and is never a command.
- Operand mapping:
  - alu_inb = reg[b[3:0]].
  - alu_ina = a (immediate) for SET, ADD, SUB, WRITE, CHECK, LESS.
  - alu_ina = reg[a[3:0]] for ADDREG, CHECKR, COPY, AUP, ADW, MOD, DIV, INV.
  - Destination = b[3:0].
- FSM (IDLE, FETCH, EXEC, WB, HALTED):
  - IDLE: alu_op=FF. start -> pc=START_PC, busy=1, FETCH. start while busy is ignored.
  - FETCH: rom_req=1, rom_addr=pc. On rom_ack, latch rom_data, drop rom_req next edge, go to EXEC. Unbounded wait.
  - EXEC (1 cycle): register alu_op/ina/inb from the latched instruction; they are stable from the following cycle through WB.
  - EXEC with a jump opcode: ALU outputs stay FF/0, go straight to FETCH.
    - JMP: pc=a.
    - JZ: pc = zf ? a : pc+1.
    - JNZ: pc = !zf ? a : pc+1.
  - EXEC with HALT: go to HALTED.
  - WB (1 cycle): sample ALU outputs, pc=pc+1, alu_op=FF, go to FETCH.
    - CHECK/CHECKR/LESS: zf <= alu_zf, no register write.
    - Other ALU ops: reg[b[3:0]] <= alu_out.
    - Unknown opcodes: no write, zf unchanged.
- HALTED: done=1 for exactly one cycle, busy=0, then IDLE. Registers and zf are retained until reset.
- Latency per ALU instruction: ROM wait + 3 cycles. Jumps: ROM wait + 2.
- pc is 8-bit and wraps FF->00 silently.
- A write to the register currently selected by dbg_addr is visible on dbg_data the cycle after WB.

Optional Feature:
- Macro SEQ_RETIRE_CNT_EN.
- Defined: adds output retired_cnt [15:0].
  - Cleared on reset and on accepted start.
  - Increments once per instruction leaving EXEC/WB, including jumps and HALT.
  - Saturates at FFFF.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset and basic write:
  - Program SET a=07 b=3; HALT; rom_ack same cycle as req.
  - Expect reg3=07, done pulse 1 cycle, busy low after, zf=0.
- Register operations:
  - SET 05->r1; SET 09->r2; ADDREG a=1 b=2.
  - Expect r2=0E; alu_op=FF observed during every FETCH.
- Compare and branch taken:
  - SET 04->r0; CHECK a=04 b=0; JZ a=10; ROM[10]=HALT.
  - Expect zf=1, pc sequence 00,01,02,10; r0 unchanged.
- Branch not taken, plus ROM stall:
  - CHECK a=01 b=0 (r0=04); JZ a=10; HALT at 03.
  - rom_ack delayed 5 cycles each fetch; rom_req held steady throughout.
  - Expect pc reaches 03, zf=0.
- Reset mid-operation:
  - Assert rst_n=0 while in FETCH with rom_req=1.
  - Expect rom_req=0 and all regs=0 next cycle; later rom_ack ignored; start restarts at 00.
- Retire counter (with SEQ_RETIRE_CNT_EN defined):
  - Run the branch-taken program.
  - Expect retired_cnt=4; second start clears it to 0.
